// File: rtl/btn_pkg.sv
// Shared definitions for the button gesture decoder: state encoding and default tick counts.
package btn_pkg;

    localparam int LONG_TICKS_DEF = 500;
    localparam int DBL_TICKS_DEF  = 250;
    localparam int CNT_W_DEF      = 10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_LONG   = 3'd2;
    localparam logic [2:0] ST_WAIT2  = 3'd3;
    localparam logic [2:0] ST_PRESS2 = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_PRESS1 = ST_PRESS1,
        S_LONG   = ST_LONG,
        S_WAIT2  = ST_WAIT2,
        S_PRESS2 = ST_PRESS2
    } state_t;

endpackage

// File: rtl/btn_event_decoder_if.sv
// Button level and tick in, one-cycle gesture strobes plus hold level out.
interface btn_event_decoder_if;

    logic ce;
    logic btn_lvl;
    logic short_ceo;
    logic long_ceo;
    logic double_ceo;
    logic hold;

    modport master (
        output ce,
        output btn_lvl,
        input  short_ceo,
        input  long_ceo,
        input  double_ceo,
        input  hold
    );

    modport slave (
        input  ce,
        input  btn_lvl,
        output short_ceo,
        output long_ceo,
        output double_ceo,
        output hold
    );

endinterface

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into short/long/double-click strobes and a hold level.
// Edges always take priority over the terminal tick of the current timing window.
import btn_pkg::*;

module btn_event_decoder #(
    parameter int LONG_TICKS = LONG_TICKS_DEF,
    parameter int DBL_TICKS  = DBL_TICKS_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input logic           clk,
    input logic           rst_n,
    btn_event_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             lvl_q;
    logic             press;
    logic             rel;
    logic             short_next;
    logic             long_next;
    logic             double_next;
    logic             hold_next;
    logic             short_q;
    logic             long_q;
    logic             double_q;
    logic             hold_q;

    assign press = bus.btn_lvl & ~lvl_q;
    assign rel   = ~bus.btn_lvl & lvl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            lvl_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            lvl_q <= bus.btn_lvl;
        end
    end

    // Counter is cleared on every state change so each window starts from zero.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (press) begin
                    state_next = S_PRESS1;
                    cnt_next   = '0;
                end
            end
            S_PRESS1: begin
                if (rel) begin
                    state_next = S_WAIT2;
                    cnt_next   = '0;
                end else if (bus.ce) begin
                    if (cnt == LONG_LAST) begin
                        state_next = S_LONG;
                        cnt_next   = '0;
                        long_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            S_LONG: begin
                if (rel) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            end
            S_WAIT2: begin
                if (press) begin
                    state_next = S_PRESS2;
                    cnt_next   = '0;
                end else if (bus.ce) begin
                    if (cnt == DBL_LAST) begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                        short_next = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            S_PRESS2: begin
                if (rel) begin
                    state_next  = S_IDLE;
                    cnt_next    = '0;
                    double_next = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
        hold_next = (state_next == S_LONG);
    end

    // Registered outputs: strobes appear one clock after the deciding cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            short_q  <= short_next;
            long_q   <= long_next;
            double_q <= double_next;
            hold_q   <= hold_next;
        end
    end

    assign bus.short_ceo  = short_q;
    assign bus.long_ceo   = long_q;
    assign bus.double_ceo = double_q;
    assign bus.hold       = hold_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Table-driven gesture scenarios with an event scoreboard, plus hand-written reset sequences.
module tb_btn_event_decoder;

    localparam int L = 8;
    localparam int D = 4;

    typedef enum int {SC_SHORT, SC_LONG, SC_DOUBLE, SC_TWO_SHORT} scen_kind_t;

    typedef struct {
        scen_kind_t kind;
        int         h1;
        int         g;
        int         h2;
        int         ce_per;
        int         exp_count;
        string      name;
    } scen_t;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    cyc = 0;
    int    ce_per = 1;
    bit    mon_en = 1'b0;
    ev_t   exp_q[$];
    int    hold_lo = -1;
    int    hold_hi = -1;
    int    seen = 0;
    int    compared = 0;
    int    mismatched = 0;
    scen_t table_v[12];

    btn_event_decoder_if bus();

    btn_event_decoder #(
        .LONG_TICKS(L),
        .DBL_TICKS (D),
        .CNT_W     (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.ce = ((cyc % ce_per) == 0);

    function automatic string kname(input int k);
        case (k)
            0: return "SHORT";
            1: return "LONG";
            2: return "DOUBLE";
            default: return "NONE";
        endcase
    endfunction

    // Cycle index of the n-th CE tick at or after cycle 'start'.
    function automatic int nth_ce(input int start, input int n);
        int k;
        k = 0;
        for (int c = start; c < start + 10000; c++) begin
            if ((c % ce_per) == 0) k++;
            if (k == n) return c;
        end
        return -1;
    endfunction

    function automatic void push_ev(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            int   n;
            int   k;
            ev_t  e;
            logic exp_hold;
            n = ((bus.short_ceo === 1'b1) ? 1 : 0) + ((bus.long_ceo === 1'b1) ? 1 : 0)
              + ((bus.double_ceo === 1'b1) ? 1 : 0);
            if (n > 0) begin
                k = (bus.long_ceo === 1'b1) ? 1 : ((bus.double_ceo === 1'b1) ? 2 : 0);
                seen++;
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL strobe_unexpected: got %s (%0d active) at cycle %0d, required none",
                             kname(k), n, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (n > 1 || e.kind != k || e.cyc != cyc) begin
                        mismatched++;
                        $display("[TB] FAIL strobe_event: got %s (%0d active) at cycle %0d, required %s at cycle %0d",
                                 kname(k), n, cyc, kname(e.kind), e.cyc);
                    end
                end
            end
            exp_hold = (hold_lo >= 0 && cyc >= hold_lo && cyc <= hold_hi);
            compared++;
            if (bus.hold !== exp_hold) begin
                mismatched++;
                $display("[TB] FAIL hold_level: got %b at cycle %0d, required %b", bus.hold, cyc, exp_hold);
            end
        end
    end

    task automatic drive_for(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            bus.btn_lvl = lvl;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input logic es, input logic el, input logic ed, input logic eh,
                               input string nm);
        compared++;
        if ({bus.short_ceo, bus.long_ceo, bus.double_ceo, bus.hold} !== {es, el, ed, eh}) begin
            mismatched++;
            $display("[TB] FAIL %s: got s/l/d/h=%b%b%b%b, required %b%b%b%b", nm,
                     bus.short_ceo, bus.long_ceo, bus.double_ceo, bus.hold, es, el, ed, eh);
        end
    endtask

    task automatic check_tail(input int exp_count, input string nm);
        compared++;
        if (seen != exp_count) begin
            mismatched++;
            $display("[TB] FAIL %s_count: got %0d strobes, required %0d", nm, seen, exp_count);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL %s_missing: got %0d expected strobes never seen, required 0", nm, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic applyStimulus(input scen_t sc);
        int s;
        int rel1;
        int rel2;
        int t;
        ce_per = sc.ce_per;
        drive_for(1'b0, 2);
        s       = cyc;
        rel1    = s + sc.h1;
        rel2    = rel1 + sc.g + sc.h2;
        seen    = 0;
        hold_lo = -1;
        hold_hi = -1;
        case (sc.kind)
            SC_SHORT: push_ev(0, nth_ce(rel1 + 1, D) + 1);
            SC_LONG: begin
                t = nth_ce(s + 1, L) + 1;
                push_ev(1, t);
                hold_lo = t;
                hold_hi = rel1;
            end
            SC_DOUBLE: push_ev(2, rel2 + 1);
            default: begin
                push_ev(0, nth_ce(rel1 + 1, D) + 1);
                push_ev(0, nth_ce(rel2 + 1, D) + 1);
            end
        endcase
        drive_for(1'b1, sc.h1);
        drive_for(1'b0, sc.g);
        if (sc.h2 > 0) drive_for(1'b1, sc.h2);
        drive_for(1'b0, 40);
        check_tail(sc.exp_count, sc.name);
    endtask

    initial begin
        int c;
        int t;

        table_v[0]  = '{SC_SHORT,     3,  0, 0,  1, 1, "short"};
        table_v[1]  = '{SC_LONG,      20, 0, 0,  1, 1, "long"};
        table_v[2]  = '{SC_DOUBLE,    2,  2, 2,  1, 1, "double"};
        table_v[3]  = '{SC_TWO_SHORT, 2,  6, 2,  1, 2, "window_miss"};
        table_v[4]  = '{SC_SHORT,     8,  0, 0,  1, 1, "rel_on_long_tick"};
        table_v[5]  = '{SC_LONG,      9,  0, 0,  1, 1, "rel_after_long"};
        table_v[6]  = '{SC_DOUBLE,    2,  4, 2,  1, 1, "press_on_dbl_tick"};
        table_v[7]  = '{SC_TWO_SHORT, 2,  5, 2,  1, 2, "press_after_dbl_tick"};
        table_v[8]  = '{SC_DOUBLE,    2,  2, 12, 1, 1, "double_long_second"};
        table_v[9]  = '{SC_SHORT,     3,  0, 0,  4, 1, "short_ce4"};
        table_v[10] = '{SC_LONG,      40, 0, 0,  4, 1, "long_ce4"};
        table_v[11] = '{SC_DOUBLE,    3,  6, 3,  4, 1, "double_ce4"};

        rst_n       = 1'b0;
        bus.btn_lvl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput(1'b0, 1'b0, 1'b0, 1'b0, "reset_state");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 12; i++) applyStimulus(table_v[i]);

        // Reset during a held long press, then release reset with the button still down.
        ce_per = 1;
        drive_for(1'b0, 2);
        seen    = 0;
        t       = nth_ce(cyc + 1, L) + 1;
        push_ev(1, t);
        hold_lo = t;
        hold_hi = 1000000;
        drive_for(1'b1, 12);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        checkOutput(1'b0, 1'b0, 1'b0, 1'b0, "reset_in_long");
        check_tail(1, "long_before_reset");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        c       = cyc;
        seen    = 0;
        t       = nth_ce(c + 1, L) + 1;
        push_ev(1, t);
        hold_lo = t;
        hold_hi = c + 12;
        mon_en  = 1'b1;
        drive_for(1'b1, 12);
        drive_for(1'b0, 30);
        check_tail(1, "pressed_at_reset_release");

        // Reset inside the second press of a double click discards the gesture.
        drive_for(1'b0, 2);
        seen    = 0;
        hold_lo = -1;
        hold_hi = -1;
        drive_for(1'b1, 2);
        drive_for(1'b0, 2);
        drive_for(1'b1, 2);
        mon_en      = 1'b0;
        rst_n       = 1'b0;
        bus.btn_lvl = 1'b0;
        #1;
        checkOutput(1'b0, 1'b0, 1'b0, 1'b0, "reset_in_press2");
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        drive_for(1'b0, 30);
        check_tail(0, "after_press2_reset");

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/btn_event_decoder.md
# btn_event_decoder

Classifies a debounced, clock-synchronous button level into single-cycle gesture events: short press, long press, and double click. It also provides a hold level while a long press continues. It sits downstream of the button filter, takes the filtered level plus the same slow CE tick, and hands one-cycle event strobes to the control logic (mode/counter FSMs).

## Interface

- LONG_TICKS, default 500: CE ticks the button must stay pressed for a long press; legal range ≥ 2.
- DBL_TICKS, default 250: CE ticks after a short release within which a second press makes a double click; legal range ≥ 1.
- CNT_W, default 10: tick counter width; must satisfy 2^CNT_W > max(LONG_TICKS, DBL_TICKS).
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CE  in  1  time-base tick, one CLK wide (same tick as the filter).
- BTN_LVL  in  1  debounced button level, already synchronous to CLK; 1 means pressed.
- SHORT_CEO  out  1  one-cycle strobe: single short press confirmed.
- LONG_CEO  out  1  one-cycle strobe: long-press threshold reached.
- DOUBLE_CEO  out  1  one-cycle strobe: double click completed.
- HOLD  out  1  level, high while a long press is held.

## Operation

- Internal registers:
  - `lvl_q`: previous BTN_LVL.
  - `press = BTN_LVL & ~lvl_q`.
  - `rel = ~BTN_LVL & lvl_q`.
  - `cnt[CNT_W-1:0]` tick counter.
  - State register.
- IDLE: on `press`, go to PRESS1 and set cnt = 0.
- PRESS1:
  - On `rel`, go to WAIT2 and set cnt = 0.
  - Otherwise, on CE, increment cnt.
  - If CE arrives and cnt == LONG_TICKS-1, pulse LONG_CEO and go to LONG_HELD.
- LONG_HELD: HOLD = 1. On `rel`, go to IDLE. No further strobes.
- WAIT2:
  - On `press`, go to PRESS2.
  - Otherwise, on CE, increment cnt.
  - If CE arrives and cnt == DBL_TICKS-1, pulse SHORT_CEO and go to IDLE.
- PRESS2: on `rel`, pulse DOUBLE_CEO and go to IDLE. There is no timeout; holding the second press beyond LONG_TICKS still yields only DOUBLE_CEO on release.
- Priority on simultaneous events: the edge wins over the terminal tick.
  - `rel` and terminal CE in the same cycle in PRESS1: go to WAIT2, no LONG_CEO.
  - `press` and terminal CE in the same cycle in WAIT2: go to PRESS2, no SHORT_CEO.
- At most one strobe is asserted in any cycle; strobes are mutually exclusive by construction.
- cnt never wraps, because the terminal compare exits the state first. cnt is cleared on every state entry.
- CE held low freezes all timing; edges are still processed.

## Timing

- Reset (RST_N low) is asynchronous. It forces:
  - state = IDLE, cnt = 0, lvl_q = 0;
  - SHORT_CEO = LONG_CEO = DOUBLE_CEO = HOLD = 0.
- On release of reset, a button already pressed produces `press` on the first clock, because lvl_q = 0.
- Reset mid-gesture discards the gesture with no strobe.
- All outputs are registered.
- Strobe latency is exactly one CLK after the deciding cycle:
  - the `rel` cycle for DOUBLE_CEO;
  - the terminal CE cycle for SHORT_CEO and LONG_CEO.
- HOLD rises together with LONG_CEO. It falls one CLK after the `rel` cycle.
- Strobes are exactly one CLK wide regardless of CE.
- Long press: LONG_CEO follows the LONG_TICKS-th CE tick counted after the cycle in which `press` was seen.

## Structure

- Shared package `btn_pkg`:
  - state encoding localparams ST_IDLE, ST_PRESS1, ST_LONG, ST_WAIT2, ST_PRESS2 (3-bit, binary);
  - default tick constants.
- No sub-module: a single always-block FSM plus counter, with a separate output register block.
- The top level instantiates it directly after BTN_FLTR's level path.

## Test plan

Bench parameters: LONG_TICKS = 8, DBL_TICKS = 4, CE = 1 every cycle unless stated.

- Short press: BTN_LVL high 3 cycles, then low → SHORT_CEO pulses once, 4 CE ticks after release + 1 cycle; no other strobe.
- Long press: BTN_LVL high 20 cycles → LONG_CEO pulse 9 cycles after the rising edge. HOLD is high from the same cycle until 1 cycle after release. No SHORT_CEO afterwards.
- Double click: high 2, low 2, high 2, low → DOUBLE_CEO pulses 1 cycle after the second falling edge; SHORT_CEO never asserts.
- Double-click window miss: high 2, low 6, high 2, low → two SHORT_CEO pulses, no DOUBLE_CEO.
- Boundary and CE gating, checked as two cases:
  - Release coincident with the 8th tick → WAIT2 path, SHORT_CEO only.
  - CE asserted 1 cycle in 4 → all timing scales by 4×.
- Reset mid-PRESS2: drive RST_N low for 1 cycle → all outputs 0 immediately. The subsequent release yields no strobe (BTN_LVL low after reset leaves lvl_q = 0, so no `rel`).
